// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared types and constants for the RV32I register file
// and its pending-write scoreboard.
//   RegBus      - 32-bit register data word
//   RegAddrBus  - 5-bit architectural register index
//   PendCntBus  - per-register pending-write counter
//   RstActive   - level of rst that holds the block in reset
package regfile_sb_pkg;

  localparam int RegNum     = 32;
  localparam int RegBusW    = 32;
  localparam int RegAddrW   = 5;
  localparam int PendCntW   = 2;

  typedef logic [RegBusW-1:0]  reg_bus_t;
  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [PendCntW-1:0] pend_cnt_t;

  localparam reg_addr_t NOPRegAddr   = '0;
  localparam reg_bus_t  ZeroWord     = '0;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      ReadEnable   = 1'b1;
  localparam logic      RstActive    = 1'b0;

endpackage

// File: rtl/regfile_sb_rport.sv
// regfile_rport: one combinational read port of the register file.
// Returns zero for a disabled port or x0, forwards the writeback data
// when the port reads the register being written this cycle, and flags
// the operand as busy while writes to it are still in flight.
//   i_re, i_raddr         - read enable and address from ID
//   i_wb_wreg/rd/wdata    - writeback from MEM/WB (for bypass and retire)
//   i_reg_data            - stored value of regs[i_raddr]
//   i_cnt                 - pending count of regs[i_raddr]
//   o_rdata, o_busy       - operand value and stall request
module regfile_rport
  import regfile_sb_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             i_re,
  input  reg_addr_t        i_raddr,
  input  logic             i_wb_wreg,
  input  reg_addr_t        i_wb_rd,
  input  reg_bus_t         i_wb_wdata,
  input  reg_bus_t         i_reg_data,
  input  logic [CNT_W-1:0] i_cnt,
  output reg_bus_t         o_rdata,
  output logic             o_busy
);

  logic w_active;
  logic w_hit;

  assign w_active = (i_re == ReadEnable) && (i_raddr != NOPRegAddr);
  assign w_hit    = (i_wb_wreg == WriteEnable) && (i_wb_rd == i_raddr);

  always_comb begin
    o_rdata = ZeroWord;
    if (w_active) begin
      o_rdata = w_hit ? i_wb_wdata : i_reg_data;
    end
  end

  // A write retiring this cycle no longer blocks the reader: its data is
  // already on the bypass, so only the remaining in-flight writes count.
  assign o_busy = w_active && (i_cnt > CNT_W'(w_hit));

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: architectural register file with per-register pending-write
// scoreboard for the five-stage RV32I core.
//   clk, rst                    - clock, synchronous active-low reset
//   wb_wreg, wb_rd, wb_wdata    - writeback (also retires one pending write)
//   re1/raddr1, re2/raddr2      - two read ports to ID
//   rdata1/rdata2, busy1/busy2  - combinational read data and stall flags
//   issue_i, issue_rd           - ID issued an instruction writing issue_rd
//   cancel_i, cancel_rd         - a pending write was squashed before WB
//   issue_full                  - issue_rd has the maximum writes in flight
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int REG_NUM = RegNum,
  parameter int CNT_W   = PendCntW
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_wreg,
  input  reg_addr_t wb_rd,
  input  reg_bus_t  wb_wdata,
  input  logic      re1,
  input  reg_addr_t raddr1,
  output reg_bus_t  rdata1,
  output logic      busy1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output reg_bus_t  rdata2,
  output logic      busy2,
  input  logic      issue_i,
  input  reg_addr_t issue_rd,
  input  logic      cancel_i,
  input  reg_addr_t cancel_rd,
  output logic      issue_full
);

  reg_bus_t         r_regs [REG_NUM];
  logic [CNT_W-1:0] r_cnt  [REG_NUM];

  // cnt + inc - ret - can, clamped to 0..2^CNT_W-1. The sum is held two
  // bits wider so the sign bit marks underflow and the next bit overflow.
  function automatic logic [CNT_W-1:0] sat_next(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             ret,
    input logic             can
  );
    logic signed [CNT_W+1:0] sum;
    sum = $signed({2'b00, cnt})
        + $signed({{(CNT_W+1){1'b0}}, inc})
        - $signed({{(CNT_W+1){1'b0}}, ret})
        - $signed({{(CNT_W+1){1'b0}}, can});
    if (sum[CNT_W+1]) begin
      return '0;
    end else if (sum[CNT_W]) begin
      return '1;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst == RstActive) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= ZeroWord;
        r_cnt[i]  <= '0;
      end
    end else begin
      if ((wb_wreg == WriteEnable) && (wb_rd != NOPRegAddr)) begin
        r_regs[wb_rd] <= wb_wdata;
      end
      // x0 never has a pending write; its counter is pinned at zero.
      r_cnt[0] <= '0;
      for (int i = 1; i < REG_NUM; i++) begin
        r_cnt[i] <= sat_next(r_cnt[i],
                             issue_i  && (issue_rd  == RegAddrW'(i)),
                             wb_wreg  && (wb_rd     == RegAddrW'(i)),
                             cancel_i && (cancel_rd == RegAddrW'(i)));
      end
    end
  end

  assign issue_full = (issue_rd != NOPRegAddr) && (&r_cnt[issue_rd]);

  regfile_rport #(.CNT_W(CNT_W)) u_rport1 (
    .i_re       (re1),
    .i_raddr    (raddr1),
    .i_wb_wreg  (wb_wreg),
    .i_wb_rd    (wb_rd),
    .i_wb_wdata (wb_wdata),
    .i_reg_data (r_regs[raddr1]),
    .i_cnt      (r_cnt[raddr1]),
    .o_rdata    (rdata1),
    .o_busy     (busy1)
  );

  regfile_rport #(.CNT_W(CNT_W)) u_rport2 (
    .i_re       (re2),
    .i_raddr    (raddr2),
    .i_wb_wreg  (wb_wreg),
    .i_wb_rd    (wb_rd),
    .i_wb_wdata (wb_wdata),
    .i_reg_data (r_regs[raddr2]),
    .i_cnt      (r_cnt[raddr2]),
    .o_rdata    (rdata2),
    .o_busy     (busy2)
  );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        busy1, busy2;
  logic        issue_i;
  logic [4:0]  issue_rd;
  logic        cancel_i;
  logic [4:0]  cancel_rd;
  logic        issue_full;

  regfile_sb dut (
    .clk        (clk),
    .rst        (rst),
    .wb_wreg    (wb_wreg),
    .wb_rd      (wb_rd),
    .wb_wdata   (wb_wdata),
    .re1        (re1),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .busy1      (busy1),
    .re2        (re2),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .busy2      (busy2),
    .issue_i    (issue_i),
    .issue_rd   (issue_rd),
    .cancel_i   (cancel_i),
    .cancel_rd  (cancel_rd),
    .issue_full (issue_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic        b1;
    logic [31:0] r2;
    logic        b2;
    logic        full;
  } exp_t;

  exp_t exp_q[$];
  logic vld;
  int   tests;
  int   fails;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, req);
    end
  endtask

  // Monitor: whenever the stimulus marks the cycle as valid, pop the
  // expected response and compare against the DUT away from the edge.
  always @(negedge clk) begin
    if (vld) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: valid cycle with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp({e.name, ".rdata1"}, rdata1, e.r1);
        cmp({e.name, ".busy1"}, {31'd0, busy1}, {31'd0, e.b1});
        cmp({e.name, ".rdata2"}, rdata2, e.r2);
        cmp({e.name, ".busy2"}, {31'd0, busy2}, {31'd0, e.b2});
        cmp({e.name, ".issue_full"}, {31'd0, issue_full}, {31'd0, e.full});
      end
    end
  end

  task automatic idle();
    wb_wreg   = 1'b0;
    wb_rd     = 5'd0;
    wb_wdata  = 32'h0;
    re1       = 1'b0;
    re2       = 1'b0;
    raddr1    = 5'd0;
    raddr2    = 5'd0;
    issue_i   = 1'b0;
    issue_rd  = 5'd0;
    cancel_i  = 1'b0;
    cancel_rd = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    vld = 1'b0;
    idle();
  endtask

  task automatic expect_out(input string nm, input logic [31:0] r1, input logic b1,
                            input logic [31:0] r2, input logic b2, input logic full);
    exp_t e;
    e.name = nm; e.r1 = r1; e.b1 = b1; e.r2 = r2; e.b2 = b2; e.full = full;
    exp_q.push_back(e);
    vld = 1'b1;
  endtask

  task automatic rd1(input logic [4:0] a);
    re1 = 1'b1; raddr1 = a;
  endtask

  task automatic rd2(input logic [4:0] a);
    re2 = 1'b1; raddr2 = a;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_wreg = 1'b1; wb_rd = rd; wb_wdata = d;
  endtask

  task automatic iss(input logic [4:0] rd);
    issue_i = 1'b1; issue_rd = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    vld   = 1'b0;
    rst   = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Every register reads zero after reset, nothing busy or full.
    for (int r = 0; r < 32; r++) begin
      rd1(5'(r));
      rd2(5'(31 - r));
      issue_rd = 5'(r);
      expect_out("reset_read", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end

    // Write x5; the write cycle itself forwards.
    wb(5'd5, 32'hDEADBEEF); rd1(5'd5);
    expect_out("wr_x5_bypass", 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rd1(5'd5); wb(5'd0, 32'h00001234); rd2(5'd0);
    expect_out("rd_x5_wr_x0", 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rd1(5'd5); rd2(5'd0);
    expect_out("rd_x0_after_wr", 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    re1 = 1'b0; raddr1 = 5'd5; rd2(5'd5);
    expect_out("read_disabled", 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();

    // Same-cycle bypass on x7.
    wb(5'd7, 32'hA5A5A5A5); rd1(5'd7); rd2(5'd5);
    expect_out("bypass_x7", 32'hA5A5A5A5, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();

    // Scoreboard depth on x3.
    iss(5'd3); rd1(5'd3);
    expect_out("x3_issue1", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    iss(5'd3); rd1(5'd3);
    expect_out("x3_issue2", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    iss(5'd3); rd1(5'd3); rd2(5'd3);
    expect_out("x3_issue3", 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    issue_rd = 5'd3; rd1(5'd3);
    expect_out("x3_full", 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    iss(5'd3); rd1(5'd3);
    expect_out("x3_issue_while_full", 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    issue_rd = 5'd3; wb(5'd3, 32'h11); rd1(5'd3);
    expect_out("x3_retire1", 32'h11, 1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    issue_rd = 5'd3; wb(5'd3, 32'h22); rd1(5'd3);
    expect_out("x3_retire2", 32'h22, 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    wb(5'd3, 32'h33); rd1(5'd3);
    expect_out("x3_retire3", 32'h33, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rd1(5'd3); issue_rd = 5'd3;
    expect_out("x3_idle", 32'h33, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();

    // Issue and retire together on x4 leave the count at 1.
    iss(5'd4);
    expect_out("x4_issue", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    iss(5'd4); wb(5'd4, 32'h44); rd1(5'd4);
    expect_out("x4_iss_ret", 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rd1(5'd4);
    expect_out("x4_cnt_held", 32'h44, 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    cancel_i = 1'b1; cancel_rd = 5'd4; rd1(5'd4);
    expect_out("x4_cancel", 32'h44, 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    rd1(5'd4);
    expect_out("x4_after_cancel", 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    // Cancel at count 0 is ignored.
    cancel_i = 1'b1; cancel_rd = 5'd4;
    expect_out("x4_cancel_underflow", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    iss(5'd4); rd1(5'd4);
    expect_out("x4_reissue", 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    iss(5'd4); rd1(5'd4);
    expect_out("x4_reissue2", 32'h44, 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    // All three events at count 2: net -1, count 1.
    iss(5'd4); wb(5'd4, 32'h55); cancel_i = 1'b1; cancel_rd = 5'd4; rd2(5'd4);
    expect_out("x4_all_three", 32'h0, 1'b0, 32'h55, 1'b1, 1'b0);
    tick();
    rd2(5'd4);
    expect_out("x4_after_three", 32'h0, 1'b0, 32'h55, 1'b1, 1'b0);
    tick();
    wb(5'd4, 32'h66); rd2(5'd4);
    expect_out("x4_last_retire", 32'h0, 1'b0, 32'h66, 1'b0, 1'b0);
    tick();
    rd2(5'd4);
    expect_out("x4_drained", 32'h0, 1'b0, 32'h66, 1'b0, 1'b0);
    tick();

    // Reset in the middle of pending writes to x9.
    iss(5'd9);
    expect_out("x9_issue1", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    iss(5'd9);
    expect_out("x9_issue2", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rd2(5'd9); rd1(5'd5);
    expect_out("x9_pending", 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    iss(5'd9); wb(5'd6, 32'h77);
    tick();
    rst = 1'b1;
    rd2(5'd9); rd1(5'd5); issue_rd = 5'd9;
    expect_out("post_reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    wb(5'd9, 32'h99); rd2(5'd9); rd1(5'd6);
    expect_out("x9_stale_retire", 32'h0, 1'b0, 32'h99, 1'b0, 1'b0);
    tick();
    rd2(5'd9); issue_rd = 5'd9;
    expect_out("x9_data_kept", 32'h0, 1'b0, 32'h99, 1'b0, 1'b0);
    tick();
    rd2(5'd9);
    expect_out("x9_no_underflow", 32'h0, 1'b0, 32'h99, 1'b0, 1'b0);
    tick();

    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
